// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer: FSM state encoding,
// config-word bit positions, sticky error bit positions and core reset hold time.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        RST_HOLD,
        IDLE,
        CFG,
        LOAD
    } seq_state_e;

    localparam int CFG_DIR_BIT = 0;

    localparam int ERR_W             = 3;
    localparam int ERR_TLAST_UNEXP   = 0;
    localparam int ERR_TLAST_MISSING = 1;
    localparam int ERR_OUT_FRAME     = 2;

    // Clocks the core's aresetn stays low after rst is released.
    localparam int RST_HOLD_CYCLES = 2;

endpackage

// File: rtl/fft_rst_stretch.sv
// Holds the FFT core's active-low reset for HOLD_CYCLES clocks after rst is
// released, then raises aresetn and the done flag together.
module fft_rst_stretch
    import fft_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = RST_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    output logic aresetn,
    output logic done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (!done_q) begin
            if (cnt_q == CW'(HOLD_CYCLES)) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign aresetn = done_q;
    assign done    = done_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for the xfft core: frames the input stream, issues one
// config word per frame, tracks frames in flight and checks output framing.
// Define FFT_SEQ_STATS_EN to implement the completed-frame counter on frame_cnt.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int                     DATAWIDTH    = 48,
    parameter int                     NFFT_LOG2    = 10,
    parameter int                     CFG_WIDTH    = 16,
    parameter logic [CFG_WIDTH-2:0]   SCALE_SCH    = 15'h2AB,
    parameter int                     MAX_INFLIGHT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATAWIDTH-1:0]  s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  dir_fwd,
    output logic                  fft_aresetn,
    output logic [CFG_WIDTH-1:0]  fft_cfg_tdata,
    output logic                  fft_cfg_tvalid,
    input  logic                  fft_cfg_tready,
    output logic [DATAWIDTH-1:0]  fft_in_tdata,
    output logic                  fft_in_tvalid,
    output logic                  fft_in_tlast,
    input  logic                  fft_in_tready,
    input  logic [DATAWIDTH-1:0]  fft_out_tdata,
    input  logic                  fft_out_tvalid,
    input  logic                  fft_out_tlast,
    output logic                  fft_out_tready,
    input  logic                  evt_tlast_unexpected,
    input  logic                  evt_tlast_missing,
    output logic [DATAWIDTH-1:0]  m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  busy,
    output logic [ERR_W-1:0]      err,
    input  logic                  err_clr,
    output logic [15:0]           frame_cnt
);

    localparam int                 IW       = $clog2(MAX_INFLIGHT + 1);
    localparam logic [NFFT_LOG2-1:0] CNT_LAST = '1;

    seq_state_e             state_q, state_d;
    logic                   dir_q, dir_d;
    logic                   cfg_valid_q, cfg_valid_d;
    logic [NFFT_LOG2-1:0]   in_cnt_q, in_cnt_d;
    logic [NFFT_LOG2-1:0]   out_cnt_q, out_cnt_d;
    logic [IW-1:0]          inflight_q, inflight_d;
    logic [ERR_W-1:0]       err_q, err_d;

    logic                   rst_done;
    logic                   in_beat;
    logic                   load_last;
    logic                   out_beat;
    logic                   out_last;
    logic [ERR_W-1:0]       err_new;
    logic [CFG_WIDTH-1:0]   cfg_word;

    fft_rst_stretch #(
        .HOLD_CYCLES (RST_HOLD_CYCLES)
    ) u_rst_stretch (
        .clk     (clk),
        .rst     (rst),
        .aresetn (fft_aresetn),
        .done    (rst_done)
    );

    assign in_beat  = (state_q == LOAD) && s_tvalid && fft_in_tready;
    assign out_beat = fft_out_tvalid && m_tready;
    assign out_last = out_beat && (out_cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cfg_valid_d = cfg_valid_q;
        in_cnt_d    = in_cnt_q;
        load_last   = 1'b0;
        case (state_q)
            RST_HOLD: begin
                if (rst_done) state_d = IDLE;
            end
            IDLE: begin
                // A new frame may only start while the core has room for it.
                if (s_tvalid && (inflight_q < IW'(MAX_INFLIGHT))) begin
                    state_d     = CFG;
                    dir_d       = dir_fwd;
                    cfg_valid_d = 1'b1;
                end
            end
            CFG: begin
                if (cfg_valid_q && fft_cfg_tready) begin
                    cfg_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (in_beat) begin
                    if (in_cnt_q == CNT_LAST) begin
                        in_cnt_d  = '0;
                        load_last = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        in_cnt_d = in_cnt_q + NFFT_LOG2'(1);
                    end
                end
            end
            default: state_d = RST_HOLD;
        endcase
    end

    always_comb begin
        out_cnt_d  = out_cnt_q;
        inflight_d = inflight_q;
        err_new    = '0;
        if (out_beat) out_cnt_d = out_cnt_q + NFFT_LOG2'(1);
        case ({load_last, out_last})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
        err_new[ERR_TLAST_UNEXP]   = evt_tlast_unexpected;
        err_new[ERR_TLAST_MISSING] = evt_tlast_missing;
        err_new[ERR_OUT_FRAME]     = out_beat && (fft_out_tlast != (out_cnt_q == CNT_LAST));
        err_d = err_clr ? '0 : (err_q | err_new);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_HOLD;
            dir_q       <= 1'b0;
            cfg_valid_q <= 1'b0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cfg_valid_q <= cfg_valid_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

`ifdef FFT_SEQ_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (out_last) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0;
`endif

    always_comb begin
        cfg_word              = {SCALE_SCH, 1'b0};
        cfg_word[CFG_DIR_BIT] = dir_q;
    end

    assign fft_cfg_tdata  = cfg_word;
    assign fft_cfg_tvalid = cfg_valid_q;

    // Input side is a zero-latency pass-through gated by the LOAD state.
    assign s_tready      = (state_q == LOAD) && fft_in_tready;
    assign fft_in_tvalid = (state_q == LOAD) && s_tvalid;
    assign fft_in_tdata  = s_tdata;
    assign fft_in_tlast  = (state_q == LOAD) && (in_cnt_q == CNT_LAST);

    assign fft_out_tready = m_tready;
    assign m_tdata        = fft_out_tdata;
    assign m_tvalid       = fft_out_tvalid;
    assign m_tlast        = fft_out_tlast;

    assign busy = (state_q != IDLE) || (inflight_q != '0);
    assign err  = err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized self-checking bench for fft_frame_sequencer with N=8, MAX_INFLIGHT=2;
// the bench models the source, the FFT core and the expected framing behaviour.
module tb_fft_frame_sequencer;

    localparam int             DW    = 48;
    localparam int             NLOG  = 3;
    localparam int             N     = 1 << NLOG;
    localparam int             CW    = 16;
    localparam logic [CW-2:0]  SCALE = 15'h2AAB;
    localparam int             MAXI  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [DW-1:0]  s_tdata;
    logic           s_tvalid, s_tready, dir_fwd;
    logic           fft_aresetn;
    logic [CW-1:0]  fft_cfg_tdata;
    logic           fft_cfg_tvalid, fft_cfg_tready;
    logic [DW-1:0]  fft_in_tdata;
    logic           fft_in_tvalid, fft_in_tlast, fft_in_tready;
    logic [DW-1:0]  fft_out_tdata;
    logic           fft_out_tvalid, fft_out_tlast, fft_out_tready;
    logic           evt_tlast_unexpected, evt_tlast_missing;
    logic [DW-1:0]  m_tdata;
    logic           m_tvalid, m_tlast, m_tready;
    logic           busy;
    logic [2:0]     err;
    logic           err_clr;
    logic [15:0]    frame_cnt;

    fft_frame_sequencer #(
        .DATAWIDTH    (DW),
        .NFFT_LOG2    (NLOG),
        .CFG_WIDTH    (CW),
        .SCALE_SCH    (SCALE),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_tdata              (s_tdata),
        .s_tvalid             (s_tvalid),
        .s_tready             (s_tready),
        .dir_fwd              (dir_fwd),
        .fft_aresetn          (fft_aresetn),
        .fft_cfg_tdata        (fft_cfg_tdata),
        .fft_cfg_tvalid       (fft_cfg_tvalid),
        .fft_cfg_tready       (fft_cfg_tready),
        .fft_in_tdata         (fft_in_tdata),
        .fft_in_tvalid        (fft_in_tvalid),
        .fft_in_tlast         (fft_in_tlast),
        .fft_in_tready        (fft_in_tready),
        .fft_out_tdata        (fft_out_tdata),
        .fft_out_tvalid       (fft_out_tvalid),
        .fft_out_tlast        (fft_out_tlast),
        .fft_out_tready       (fft_out_tready),
        .evt_tlast_unexpected (evt_tlast_unexpected),
        .evt_tlast_missing    (evt_tlast_missing),
        .m_tdata              (m_tdata),
        .m_tvalid             (m_tvalid),
        .m_tlast              (m_tlast),
        .m_tready             (m_tready),
        .busy                 (busy),
        .err                  (err),
        .err_clr              (err_clr),
        .frame_cnt            (frame_cnt)
    );

    // Reference model state: source queue, core frame buffers, frame bookkeeping.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] core_frame[$];
    logic [DW-1:0] core_out_q[$];
    int  in_idx, out_idx, inject_beat;
    int  loaded, unloaded, frames_out, cfg_count, infl_start_prev;
    bit  in_frame, cfg_v_prev, s_hs, out_hs, dir_rand_en;
    int  s_prob, in_prob, m_prob, ov_prob;
    bit  rst_req, clr_req, evt_u_req, evt_m_req;
    int  n_cmp, n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic add_samples(input int n);
        logic [63:0] r;
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom()};
            src_q.push_back(r[DW-1:0]);
        end
    endtask

    task automatic reset_model();
        core_frame.delete();
        core_out_q.delete();
        in_idx = 0; out_idx = 0; loaded = 0; unloaded = 0;
        frames_out = 0; cfg_count = 0; infl_start_prev = 0;
        in_frame = 0; cfg_v_prev = 0; s_hs = 0; out_hs = 0;
    endtask

    // One clock: drive at the falling edge, settle, then sample and update the model.
    task automatic cycle();
        int infl_now;
        @(negedge clk);
        if (s_hs) begin
            src_q.delete(0);
            s_tvalid = 1'b0;
        end
        if (out_hs) begin
            core_out_q.delete(0);
            out_idx = (out_idx + 1) % N;
            fft_out_tvalid = 1'b0;
        end
        if (!s_tvalid && src_q.size() > 0 && hit(s_prob)) begin
            s_tvalid = 1'b1;
            s_tdata  = src_q[0];
        end
        if (!fft_out_tvalid && core_out_q.size() > 0 && hit(ov_prob)) begin
            fft_out_tvalid = 1'b1;
            fft_out_tdata  = core_out_q[0];
            fft_out_tlast  = (out_idx == N - 1) ^ (out_idx == inject_beat);
        end
        fft_in_tready  = hit(in_prob);
        fft_cfg_tready = hit(in_prob);
        m_tready       = hit(m_prob);
        if (dir_rand_en && in_frame) dir_fwd = 1'($urandom_range(1));
        rst                  = rst_req;
        err_clr              = clr_req;
        evt_tlast_unexpected = evt_u_req;
        evt_tlast_missing    = evt_m_req;
        if (rst_req) begin
            s_tvalid = 1'b0; fft_out_tvalid = 1'b0;
            fft_in_tready = 1'b0; fft_cfg_tready = 1'b0; m_tready = 1'b0;
        end
        #1;
        if (rst_req) begin
            reset_model();
        end else begin
            infl_now = loaded - unloaded;
            if (fft_cfg_tvalid && !cfg_v_prev)
                check("cfg_gate_inflight", 64'(infl_start_prev < MAXI), 64'(1));
            infl_start_prev = infl_now;
            cfg_v_prev      = fft_cfg_tvalid;
            if (infl_now > 0) check("busy_inflight", 64'(busy), 64'(1));
            check("out_tready", 64'(fft_out_tready), 64'(m_tready));
            check("m_tvalid", 64'(m_tvalid), 64'(fft_out_tvalid));
            if (fft_out_tvalid) begin
                check("m_tdata", 64'(m_tdata), 64'(core_out_q[0]));
                check("m_tlast", 64'(m_tlast), 64'(fft_out_tlast));
            end
            s_hs = s_tvalid && s_tready;
            if (s_hs || (fft_in_tvalid && fft_in_tready)) begin
                check("in_handshake", 64'(fft_in_tvalid && fft_in_tready), 64'(s_hs));
                check("in_beat_in_frame", 64'(in_frame), 64'(1));
                check("in_tdata", 64'(fft_in_tdata), 64'(src_q[0]));
                check("in_tlast", 64'(fft_in_tlast), 64'(in_idx == N - 1));
                core_frame.push_back(src_q[0]);
                in_idx++;
                if (in_idx == N) begin
                    in_idx = 0; in_frame = 0; loaded++;
                    foreach (core_frame[i]) core_out_q.push_back(core_frame[i]);
                    core_frame.delete();
                end
            end
            if (fft_cfg_tvalid && fft_cfg_tready) begin
                check("cfg_tdata", 64'(fft_cfg_tdata), 64'({SCALE, dir_fwd}));
                check("cfg_outside_frame", 64'(in_frame), 64'(0));
                in_frame = 1;
                cfg_count++;
            end
            out_hs = fft_out_tvalid && fft_out_tready;
            if (out_hs && out_idx == N - 1) begin
                unloaded++;
                frames_out++;
            end
        end
    endtask

    task automatic run_until_drained(input string tag, input int max_cycles);
        int k;
        k = 0;
        while (!(src_q.size() == 0 && core_frame.size() == 0 && core_out_q.size() == 0 &&
                 !fft_out_tvalid && !s_tvalid && loaded == unloaded) && k < max_cycles) begin
            cycle();
            k++;
        end
        check({tag, "_drained"}, 64'(k < max_cycles), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, lowc;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; dir_fwd = 1'b1;
        fft_cfg_tready = 1'b0; fft_in_tready = 1'b0; m_tready = 1'b0;
        fft_out_tdata = '0; fft_out_tvalid = 1'b0; fft_out_tlast = 1'b0;
        evt_tlast_unexpected = 1'b0; evt_tlast_missing = 1'b0; err_clr = 1'b0;
        s_prob = 100; in_prob = 100; m_prob = 100; ov_prob = 100;
        inject_beat = -1; dir_rand_en = 0;
        clr_req = 0; evt_u_req = 0; evt_m_req = 0;
        reset_model();

        // Reset state
        rst_req = 1;
        repeat (4) cycle();
        check("rst_aresetn", 64'(fft_aresetn), 64'(0));
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_cfg_tvalid", 64'(fft_cfg_tvalid), 64'(0));
        check("rst_in_tvalid", 64'(fft_in_tvalid), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        rst_req = 0;
        cycle();
        lowc = 0; k = 0;
        while (k < 10) begin
            cycle();
            k++;
            if (fft_aresetn) break;
            lowc++;
        end
        check("aresetn_hold_cycles", 64'(lowc), 64'(2));

        // Two back-to-back forward frames with all readys high
        dir_fwd = 1'b1;
        add_samples(16);
        k = 0;
        while (!fft_cfg_tvalid && k < 20) begin cycle(); k++; end
        check("cfg_after_reset", 64'(fft_cfg_tvalid), 64'(1));
        run_until_drained("burst", 300);
        check("burst_cfg_words", 64'(cfg_count), 64'(2));
        check("burst_frames", 64'(frames_out), 64'(2));

        // Output stalled: third frame must wait for inflight to drop
        m_prob = 0;
        add_samples(24);
        repeat (60) cycle();
        check("bp_loaded", 64'(loaded - unloaded), 64'(2));
        check("bp_cfg_blocked", 64'(fft_cfg_tvalid), 64'(0));
        check("bp_busy", 64'(busy), 64'(1));
        check("bp_pending", 64'(src_q.size()), 64'(8));
        check("bp_s_tready", 64'(s_tready), 64'(0));
        m_prob = 100;
        run_until_drained("bp", 400);
        check("bp_frames", 64'(frames_out), 64'(5));

        // Early output tlast and event/clear handling
        inject_beat = 5;
        add_samples(8);
        run_until_drained("inj", 200);
        inject_beat = -1;
        check("err_out_frame", 64'(err), 64'(3'b100));
        clr_req = 1; evt_u_req = 1; cycle();
        clr_req = 0; evt_u_req = 0; cycle();
        check("err_clr_wins", 64'(err), 64'(3'b000));
        evt_m_req = 1; cycle(); evt_m_req = 0; cycle();
        check("err_tlast_missing", 64'(err), 64'(3'b010));
        evt_u_req = 1; cycle(); evt_u_req = 0; cycle();
        check("err_tlast_unexp", 64'(err), 64'(3'b011));
        clr_req = 1; cycle(); clr_req = 0; cycle();
        check("err_cleared", 64'(err), 64'(3'b000));

        // Reset in the middle of a frame
        dir_fwd = 1'b1;
        add_samples(8);
        k = 0;
        while (in_idx != 4 && k < 50) begin cycle(); k++; end
        check("mid_reached_beat4", 64'(in_idx), 64'(4));
        rst_req = 1; cycle();
        rst_req = 0; cycle();
        check("mid_s_tready", 64'(s_tready), 64'(0));
        check("mid_aresetn", 64'(fft_aresetn), 64'(0));
        check("mid_busy", 64'(busy), 64'(1));
        dir_fwd = 1'b0;
        add_samples(4);
        run_until_drained("mid", 300);
        check("mid_cfg_words", 64'(cfg_count), 64'(1));
        check("mid_frames", 64'(frames_out), 64'(1));

        // Random traffic with random direction per frame
        s_prob = 70; in_prob = 60; m_prob = 50; ov_prob = 70;
        dir_rand_en = 1;
        add_samples(5 * N);
        run_until_drained("rand", 3000);
        check("rand_cfg_words", 64'(cfg_count), 64'(6));
        check("rand_frames", 64'(frames_out), 64'(6));
        check("final_err", 64'(err), 64'(0));
`ifdef FFT_SEQ_STATS_EN
        check("frame_cnt", 64'(frame_cnt), 64'(frames_out & 16'hFFFF));
`else
        check("frame_cnt", 64'(frame_cnt), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
